// File: rtl/cla_share_arbiter.sv
// Round-robin front end for one shared WIDTH-bit carry-lookahead adder.
// A winning requester's operands are registered into the adder. The sum is
// captured one cycle later and returned on a valid/ready response channel,
// tagged with the index of the requester that owns it.
module cla_share_arbiter #(
    parameter int unsigned WIDTH = 36,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDW   = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NREQ-1:0]         i_req_valid,
    input  logic [NREQ*WIDTH-1:0]   i_req_add1,
    input  logic [NREQ*WIDTH-1:0]   i_req_add2,
    output logic [NREQ-1:0]         o_req_ready,
    output logic [WIDTH-1:0]        o_adder_add1,
    output logic [WIDTH-1:0]        o_adder_add2,
    input  logic [WIDTH:0]          i_adder_result,
    output logic                    o_rsp_valid,
    output logic [IDW-1:0]          o_rsp_id,
    output logic [WIDTH:0]          o_rsp_result,
    input  logic                    i_rsp_ready,
    output logic                    o_busy
);

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [IDW-1:0]   id_q, id_d;
    logic [WIDTH-1:0] add1_q, add1_d;
    logic [WIDTH-1:0] add2_q, add2_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [WIDTH:0]   rsp_result_q, rsp_result_d;

    logic [IDW-1:0]   cand;
    logic [IDW-1:0]   win_idx;
    logic             win_found;
    logic             accept;
    logic             xfer;
    logic [NREQ-1:0]  grant;

    // Round-robin search starting one past the last winner, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = IDW'((32'(ptr_q) + i) % NREQ);
            if (!win_found && i_req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant only inside the accept window; a RESP cycle accepts only as the response drains.
    always_comb begin
        grant = '0;
        if (accept && win_found) begin
            grant[win_idx] = 1'b1;
        end
    end

    assign xfer        = accept && win_found;
    assign o_req_ready = grant;

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (xfer) state_d = StExec;
            StExec: state_d = StResp;
            StResp: begin
                if (i_rsp_ready) begin
                    state_d = xfer ? StExec : StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs: accept window and busy flag.
    always_comb begin
        accept = (state_q == StIdle) || ((state_q == StResp) && i_rsp_ready);
        o_busy = (state_q != StIdle);
    end

    // Datapath next-state: operand load on transfer, result capture in EXEC.
    always_comb begin
        ptr_d        = ptr_q;
        id_d         = id_q;
        add1_d       = add1_q;
        add2_d       = add2_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        if (xfer) begin
            add1_d = i_req_add1[32'(win_idx) * WIDTH +: WIDTH];
            add2_d = i_req_add2[32'(win_idx) * WIDTH +: WIDTH];
            id_d   = win_idx;
            ptr_d  = win_idx;
        end
        if (state_q == StExec) begin
            rsp_valid_d  = 1'b1;
            rsp_id_d     = id_q;
            rsp_result_d = i_adder_result;
        end else if ((state_q == StResp) && i_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // Datapath registers; pointer resets to NREQ-1 so requester 0 is searched first.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ptr_q        <= IDW'(NREQ - 1);
            id_q         <= '0;
            add1_q       <= '0;
            add2_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_result_q <= '0;
        end else begin
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            add1_q       <= add1_d;
            add2_q       <= add2_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
        end
    end

    assign o_adder_add1 = add1_q;
    assign o_adder_add2 = add2_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_result = rsp_result_q;

endmodule
